// File: rtl/cnu_min_tracker_serial_if.sv
// Beat-stream and result handshake bundle for the serial check-node min1/min2 tracker.
// valid/ready: a transfer happens on a rising edge where valid && ready; the source holds its payload until then.
interface cnu_min_tracker_serial_if #(
   parameter int QUAN_SIZE          = 3,
   parameter int LANES              = 2,
   parameter int MIN_INDEX_BITWIDTH = 4
);
   logic                          in_valid;
   logic                          in_ready;
   logic [LANES*QUAN_SIZE-1:0]    in_msg;
   logic                          out_valid;
   logic                          out_ready;
   logic [QUAN_SIZE-1:0]          m1;
   logic [QUAN_SIZE-1:0]          m2;
   logic [MIN_INDEX_BITWIDTH-1:0] min_1_index;
   logic [MIN_INDEX_BITWIDTH-1:0] min_2_index;

   modport master (
      output in_valid, in_msg, out_ready,
      input  in_ready, out_valid, m1, m2, min_1_index, min_2_index
   );

   modport slave (
      input  in_valid, in_msg, out_ready,
      output in_ready, out_valid, m1, m2, min_1_index, min_2_index
   );
endinterface

// File: rtl/cnu_min_tracker_serial.sv
// Partial-parallel min1/min2 finder: folds LANES messages per beat into a running (value, index)
// ordered pair and publishes the row result through a registered valid/ready slot.
module cnu_min_tracker_serial #(
   parameter int CN_DEGREE          = 10,
   parameter int QUAN_SIZE          = 3,
   parameter int LANES              = 2,
   parameter int MIN_INDEX_BITWIDTH = $clog2(CN_DEGREE)
) (
   input logic                    sys_clk,
   input logic                    rstn,
   input logic                    sync_clr,
   cnu_min_tracker_serial_if.slave bus
);

   localparam int BEATS  = (CN_DEGREE + LANES - 1) / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IW     = MIN_INDEX_BITWIDTH;
   localparam int QW     = QUAN_SIZE;

   typedef struct packed {
      logic          v1;
      logic [QW-1:0] m1;
      logic [IW-1:0] i1;
      logic          v2;
      logic [QW-1:0] m2;
      logic [IW-1:0] i2;
   } pair_t;

   function automatic logic ranks_before(input logic [QW-1:0] va, input logic [IW-1:0] ia,
                                         input logic [QW-1:0] vb, input logic [IW-1:0] ib);
      return (va < vb) || ((va == vb) && (ia < ib));
   endfunction

   // Insert one candidate into an ordered pair; ties go to the lower index.
   function automatic pair_t insert(input pair_t p, input logic [QW-1:0] v, input logic [IW-1:0] i);
      pair_t r;
      r = p;
      if (!p.v1 || ranks_before(v, i, p.m1, p.i1)) begin
         r.v2 = p.v1;
         r.m2 = p.m1;
         r.i2 = p.i1;
         r.v1 = 1'b1;
         r.m1 = v;
         r.i1 = i;
      end else if (!p.v2 || ranks_before(v, i, p.m2, p.i2)) begin
         r.v2 = 1'b1;
         r.m2 = v;
         r.i2 = i;
      end
      return r;
   endfunction

   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   pair_t             run_q, run_d;
   logic              out_valid_q, out_valid_d;
   logic [QW-1:0]     m1_q, m1_d, m2_q, m2_d;
   logic [IW-1:0]     i1_q, i1_d, i2_q, i2_d;

   logic  last_beat;
   logic  in_ready;
   logic  accept;
   logic  load;
   pair_t beat_p;
   pair_t seed_p;
   pair_t merged_p;

   assign last_beat = (beat_cnt_q == BEAT_W'(BEATS - 1));
   assign in_ready  = !(last_beat && out_valid_q && !bus.out_ready);
   assign accept    = bus.in_valid && in_ready;

   // Lanes past CN_DEGREE on the final beat never enter the ordering.
   always_comb begin
      beat_p = '0;
      for (int k = 0; k < LANES; k++) begin
         if (int'(beat_cnt_q) * LANES + k < CN_DEGREE) begin
            beat_p = insert(beat_p, bus.in_msg[k*QW +: QW], IW'(int'(beat_cnt_q) * LANES + k));
         end
      end
      seed_p   = (beat_cnt_q == '0) ? '0 : run_q;
      merged_p = seed_p;
      if (beat_p.v1) merged_p = insert(merged_p, beat_p.m1, beat_p.i1);
      if (beat_p.v2) merged_p = insert(merged_p, beat_p.m2, beat_p.i2);
   end

   always_comb begin
      beat_cnt_d = beat_cnt_q;
      run_d      = run_q;
      m1_d       = m1_q;
      m2_d       = m2_q;
      i1_d       = i1_q;
      i2_d       = i2_q;
      load       = 1'b0;
      if (sync_clr) begin
         beat_cnt_d = '0;
         run_d      = '0;
      end else if (accept) begin
         if (last_beat) begin
            beat_cnt_d = '0;
            run_d      = '0;
            load       = 1'b1;
            m1_d       = merged_p.m1;
            m2_d       = merged_p.m2;
            i1_d       = merged_p.i1;
            i2_d       = merged_p.i2;
         end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            run_d      = merged_p;
         end
      end
      if (load) begin
         out_valid_d = 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   always_ff @(posedge sys_clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt_q  <= '0;
         run_q       <= '0;
         out_valid_q <= 1'b0;
         m1_q        <= '0;
         m2_q        <= '0;
         i1_q        <= '0;
         i2_q        <= '0;
      end else begin
         beat_cnt_q  <= beat_cnt_d;
         run_q       <= run_d;
         out_valid_q <= out_valid_d;
         m1_q        <= m1_d;
         m2_q        <= m2_d;
         i1_q        <= i1_d;
         i2_q        <= i2_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.m1          = m1_q;
   assign bus.m2          = m2_q;
   assign bus.min_1_index = i1_q;
   assign bus.min_2_index = i2_q;

endmodule

// File: doc/cnu_min_tracker_serial.md
Name: cnu_min_tracker_serial

Overview:
- Partial-parallel min1/min2 finder for the check-node unit.
- Accepts a row of CN_DEGREE quantised variable-to-check magnitudes over several beats, LANES messages per beat.
- Tracks the running minimum, second minimum and their indices across beats, then presents a registered result through a valid/ready handshake.
- Replaces the fixed degree-10 combinational sorter tree in decoders whose degree or lane width changes per code.

Parameters:
- CN_DEGREE, 10, messages per check-node row; must be ≥ 2.
- QUAN_SIZE, 3, bit width of each message magnitude (unsigned).
- LANES, 2, messages accepted per beat; 1 ≤ LANES ≤ CN_DEGREE.
- MIN_INDEX_BITWIDTH, $clog2(CN_DEGREE), width of the index outputs.
- BEATS, (CN_DEGREE+LANES-1)/LANES, beats per row (derived; do not override).

Ports:
- sys_clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- sync_clr  in  1  synchronous abort of the partial row in progress.
- in_valid  in  1  a beat is presented.
- in_ready  out  1  the beat is accepted when in_valid && in_ready.
- in_msg  in  LANES*QUAN_SIZE  lane k in bits [k*QUAN_SIZE +: QUAN_SIZE]; global index = beat*LANES + k.
- out_valid  out  1  result registers hold a completed row.
- out_ready  in  1  consumer takes the result.
- m1  out  QUAN_SIZE  row minimum.
- m2  out  QUAN_SIZE  row second minimum.
- min_1_index  out  MIN_INDEX_BITWIDTH  index of m1.
- min_2_index  out  MIN_INDEX_BITWIDTH  index of m2.

Behaviour:
- Reset (rstn low, asynchronous):
  - beat_cnt=0; running state invalid.
  - out_valid=0; m1, m2, min_1_index, min_2_index = 0.
  - Takes effect immediately, including mid-row; the partial row is discarded.
- Accumulator: running min1/min2/idx1/idx2 registers, separate from the output registers.
  - On beat 0 the running state is seeded from that beat alone; on later beats the beat is merged with the running state.
- Merge rule: stable ordering by (value, index).
  - Ties on value: the lower index ranks first.
  - Equal minima are therefore m1=m2 with idx1 < idx2.
  - Combinational depth is one LANES-wide min2 tree plus one 4-to-2 merge.
- Partial last beat: lanes with global index ≥ CN_DEGREE are ignored regardless of their value.
- beat_cnt:
  - Increments on each accepted beat.
  - On acceptance at BEATS-1 it wraps to 0 and the merged result is written to the output registers.
  - out_valid=1 on the next edge.
  - Latency: result visible 1 cycle after the last beat is accepted.
- Output handshake:
  - out_valid clears on out_valid && out_ready unless a new result loads on the same edge, in which case out_valid stays 1 with the new values.
  - m1, m2 and both indices are stable while out_valid && !out_ready.
- in_ready:
  - 1 except when beat_cnt==BEATS-1 && out_valid && !out_ready; the last beat stalls until the output slot frees.
  - Non-last beats are always accepted, so full throughput is one row per BEATS cycles.
- sync_clr:
  - Sets beat_cnt=0 and discards the running state.
  - Does not affect out_valid or the output registers.
  - Has priority over a beat accepted in the same cycle; that beat is dropped.
- LANES==CN_DEGREE: BEATS=1, giving a fully parallel single-beat operation with 1-cycle latency.

Test Plan:
- Defaults. Beats {5,3},{7,1},{6,2},{4,7},{3,5} (indices 0..9), out_ready=1 → 1 cycle after the 5th beat: out_valid=1, m1=1, min_1_index=3, m2=2, min_2_index=5.
- Ties. All ten messages =4 → m1=4 idx 0, m2=4 idx 1. Messages 0 and 9 =0, others 7 → m1=0 idx 0, m2=0 idx 9.
- LANES=4 (BEATS=3). Same row as the first test; last beat lanes 2,3 driven 0 → lanes ignored, result identical to the first test.
- Backpressure.
  - out_ready=0 after row A completes; stream row B (all 6, message 7 =2).
  - in_ready=1 for beats 0–3 and drops at beat 4; row A outputs hold.
  - Raise out_ready for one cycle → beat 4 accepted; next edge shows m1=2 idx 7, m2=6 idx 0.
- Reset mid-row. Pull rstn low asynchronously after 2 beats of a row → outputs 0, out_valid=0 without a clock edge. Release, send the first-test row → correct result, no stale contribution.
- sync_clr. Assert sync_clr together with beat 2 of a row (a 0 at index 4) → that beat is dropped. Resend a full row of all 5 → m1=5 idx 0, m2=5 idx 1; any pending out_valid is unaffected.
